dmem_responder: RTL and testbench

- Data-memory responder at the far end of the LD/SD path: accepts one 64-bit doubleword load or store request (byte address = base + sign-extended immediate, computed upstream), services it after a fixed latency, and returns a response.
- Sits between the execute/memory stage and the data RAM array.
- Single outstanding request; valid/ready handshake on both request and response channels.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder
// Data-memory responder for 64-bit LD/SD traffic. It accepts one request at a
// time, services it LATENCY clock edges after acceptance, and then holds the
// response until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (memory contents are not reset)
//   req_valid  request present
//   req_ready  responder idle and able to accept a request
//   req_we     1 = store (SD), 0 = load (LD)
//   req_addr   byte address (base + sign-extended immediate)
//   req_wdata  store data
//   rsp_valid  response present
//   rsp_ready  consumer accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    misaligned or out-of-range access
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          lat_we;
    logic [63:0]   lat_addr;
    logic [63:0]   lat_wdata;
    logic [63:0]   mem [DEPTH];

    logic          accept;
    logic          access;
    logic          release_rsp;
    logic          acc_err;
    logic          do_write;
    logic [AW-1:0] idx;

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        access      = 1'b0;
        release_rsp = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word address compared unsigned, so negative byte addresses land far
    // above DEPTH and are flagged as out of range.
    assign acc_err  = (lat_addr[2:0] != 3'b000) ||
                      ({3'b000, lat_addr[63:3]} >= 64'(DEPTH));
    assign idx      = lat_addr[3 +: AW];
    assign do_write = access && lat_we && !acc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CW'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!acc_err && !lat_we) ? mem[idx] : '0;
            end else if (release_rsp) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive
    // rst_n; a reset forces IDLE, which blocks any pending write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// tb_dmem_responder
// Directed bench for dmem_responder. Three instances (LATENCY 2, 1 and 4)
// share clock and reset; each has its own request/response signals.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rv;
    logic [2:0]  rw;
    logic [2:0]  rr;
    logic [2:0]  qrdy;
    logic [2:0]  sv;
    logic [2:0]  se;
    logic [63:0] ra  [3];
    logic [63:0] rwd [3];
    logic [63:0] srd [3];

    int nchk  = 0;
    int nfail = 0;
    int lat [3];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[0]), .req_ready(qrdy[0]), .req_we(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]),
        .rsp_valid(sv[0]), .rsp_ready(rr[0]), .rsp_rdata(srd[0]), .rsp_err(se[0])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[1]), .req_ready(qrdy[1]), .req_we(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]),
        .rsp_valid(sv[1]), .rsp_ready(rr[1]), .rsp_rdata(srd[1]), .rsp_err(se[1])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[2]), .req_ready(qrdy[2]), .req_we(rw[2]),
        .req_addr(ra[2]), .req_wdata(rwd[2]),
        .rsp_valid(sv[2]), .rsp_ready(rr[2]), .rsp_rdata(srd[2]), .rsp_err(se[2])
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          hold;
        logic [63:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full request/response exchange on instance k. Entered and left at
    // #1 after a rising edge with the instance in IDLE.
    task automatic transact(input int k, input logic we, input logic [63:0] addr,
                            input logic [63:0] wd, input int hold,
                            input logic [63:0] exp_rd, input logic exp_err);
        int n;
        chk("req_ready_idle", 64'(qrdy[k]), 64'd1);
        rv[k]  = 1'b1;
        rw[k]  = we;
        ra[k]  = addr;
        rwd[k] = wd;
        rr[k]  = (hold == 0);
        @(posedge clk); #1;
        // scramble payload after acceptance; it must have been latched already
        rv[k]  = 1'b0;
        rw[k]  = ~we;
        ra[k]  = ~addr;
        rwd[k] = ~wd;
        n = 0;
        while (!sv[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat[k]));
        chk("rdata", srd[k], exp_rd);
        chk("err", 64'(se[k]), 64'(exp_err));
        if (hold > 0) begin
            // competing request during backpressure must be ignored
            rv[k]  = 1'b1;
            rw[k]  = 1'b1;
            ra[k]  = 64'h10;
            rwd[k] = '1;
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(sv[k]), 64'd1);
            chk("hold_rdata", srd[k], exp_rd);
            chk("hold_err", 64'(se[k]), 64'(exp_err));
            chk("hold_req_ready", 64'(qrdy[k]), 64'd0);
        end
        rr[k] = 1'b1;
        @(posedge clk); #1;
        rv[k] = 1'b0;
        chk("post_valid", 64'(sv[k]), 64'd0);
        chk("post_req_ready", 64'(qrdy[k]), 64'd1);
        chk("post_rdata", srd[k], 64'd0);
        chk("post_err", 64'(se[k]), 64'd0);
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_req_ready", 64'(qrdy[k]), 64'd1);
        chk("rst_valid", 64'(sv[k]), 64'd0);
        chk("rst_rdata", srd[k], 64'd0);
        chk("rst_err", 64'(se[k]), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] mdl [8];
        int          any_valid;

        lat = '{2, 1, 4};
        rv = '0; rw = '0; rr = '0;
        for (int i = 0; i < 3; i++) begin
            ra[i]  = '0;
            rwd[i] = '0;
        end

        tbl[0]  = '{1'b1, 64'h10,                  64'hDEADBEEF_CAFEF00D, 0, 64'h0,                  1'b0};
        tbl[1]  = '{1'b0, 64'h10,                  64'h0,                 0, 64'hDEADBEEF_CAFEF00D, 1'b0};
        tbl[2]  = '{1'b0, 64'h13,                  64'h0,                 0, 64'h0,                  1'b1};
        tbl[3]  = '{1'b1, 64'h0,                   64'h1111,              0, 64'h0,                  1'b0};
        tbl[4]  = '{1'b1, 64'h2000,                64'h5555,              0, 64'h0,                  1'b1};
        tbl[5]  = '{1'b0, 64'h0,                   64'h0,                 0, 64'h1111,               1'b0};
        tbl[6]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h7777,              0, 64'h0,                  1'b1};
        tbl[7]  = '{1'b1, 64'h1FF8,                64'hA5A5_0000_1234_5678, 0, 64'h0,                1'b0};
        tbl[8]  = '{1'b0, 64'h1FF8,                64'h0,                 0, 64'hA5A5_0000_1234_5678, 1'b0};
        tbl[9]  = '{1'b0, 64'h4,                   64'h0,                 0, 64'h0,                  1'b1};
        tbl[10] = '{1'b0, 64'h10,                  64'h0,                 5, 64'hDEADBEEF_CAFEF00D, 1'b0};

        // reset state
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) chk_reset_outputs(k);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // table vectors on the LATENCY=2 instance
        for (int i = 0; i < 11; i++) begin
            transact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                     tbl[i].rd, tbl[i].err);
        end
        // the ignored backpressure store must not have reached 0x10
        transact(0, 1'b0, 64'h10, 64'h0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0);

        // asynchronous reset mid-cycle while a response is pending
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 64'h10; rr[0] = 1'b0;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre_async_valid", 64'(sv[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs(0);
        #3 rst_n = 1'b1;
        rr[0] = 1'b1;
        @(posedge clk); #1;

        // reset while a store is still counting down
        transact(0, 1'b1, 64'h20, 64'hABCD, 0, 64'h0, 1'b0);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h20; rwd[0] = 64'h1; rr[0] = 1'b1;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        any_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (sv[0]) any_valid = 1;
        end
        chk("no_rsp_after_reset", 64'(any_valid), 64'd0);
        transact(0, 1'b0, 64'h20, 64'h0, 0, 64'hABCD, 1'b0);

        // LATENCY=1 and LATENCY=4: prefill, then random back-to-back traffic
        for (int k = 1; k < 3; k++) begin
            for (int w = 0; w < 8; w++) begin
                mdl[w] = {$urandom, $urandom};
                transact(k, 1'b1, 64'(w * 8), mdl[w], 0, 64'h0, 1'b0);
            end
            for (int t = 0; t < 10; t++) begin
                int          sel;
                int          w;
                logic        we;
                logic        err;
                logic [63:0] addr;
                logic [63:0] data;
                logic [63:0] exp_rd;
                sel  = $urandom_range(0, 9);
                w    = $urandom_range(0, 7);
                we   = 1'($urandom_range(0, 1));
                data = {$urandom, $urandom};
                if (sel < 7)       addr = 64'(w * 8);
                else if (sel == 7) addr = 64'(w * 8 + $urandom_range(1, 7));
                else if (sel == 8) addr = 64'h2000 + 64'(w * 8);
                else               addr = 64'h0 - 64'(8 * (w + 1));
                err    = (sel >= 7);
                exp_rd = (!err && !we) ? mdl[w] : 64'h0;
                transact(k, we, addr, data, $urandom_range(0, 3), exp_rd, err);
                if (!err && we) mdl[w] = data;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
